// File: rtl/shiftright_seq.sv
// Iterative right shifter (SRL/SRA), one bit per clock under a start/busy/done handshake.
// Define SHIFTR_STEP4_EN to shift four bits per clock while at least four remain.
module shiftright_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [4:0]  shamt,
    input  logic        arith,
    output logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state
);

    // Handshake: start is sampled only in IDLE, and A/shamt/arith are captured on that
    // same edge. busy is high for every SHIFT cycle. done is a one-cycle pulse in DONE,
    // and B then holds the new result until the next completion. A start seen in SHIFT
    // or DONE is dropped, not queued.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] data;
    logic [4:0]  count;
    logic        fill;

    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            B     <= 32'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            data  <= 32'd0;
            count <= 5'd0;
            fill  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        data  <= A;
                        count <= shamt;
                        fill  <= arith & A[31];
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (count == 5'd0) begin
                        B     <= data;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
`ifdef SHIFTR_STEP4_EN
                    else if (count >= 5'd4) begin
                        data  <= {{4{fill}}, data[31:4]};
                        count <= count - 5'd4;
                    end
`endif
                    else begin
                        data  <= {fill, data[31:1]};
                        count <= count - 5'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shiftright_seq.sv
// Directed self-checking bench for shiftright_seq: results, latency, busy length,
// done pulse width, dropped starts, asynchronous reset and back-to-back issue.
module tb_shiftright_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    int          n_checks;
    int          n_errors;
    int          done_pulses;
    logic [31:0] prev_b;
    logic [31:0] exp_q[$];

    shiftright_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .shamt     (shamt),
        .arith     (arith),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (done) done_pulses = done_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int n);
`ifdef SHIFTR_STEP4_EN
        return n / 4 + n % 4 + 1;
`else
        return n + 1;
`endif
    endfunction

    // driver: launch one operation, follow it to done, optionally disturb it
    task automatic run_op(input logic [31:0] a, input logic [4:0] n, input logic ar,
                          input logic [31:0] exp_b, input bit interfere);
        int j;
        int bcnt;
        int p0;
        @(negedge clk);
        A = a; shamt = n; arith = ar; start = 1'b1;
        exp_q.push_back(exp_b);
        p0 = done_pulses;
        @(posedge clk);
        #1 start = 1'b0;
        j = 0;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (j == 0) check("b_hold", B, prev_b);
            if (done) break;
            if (busy) bcnt = bcnt + 1;
            if (interfere && j == 2) begin
                start = 1'b1; A = 32'h0000FFFF; shamt = 5'd1; arith = 1'b0;
            end
            if (interfere && j == 3) start = 1'b0;
            j = j + 1;
            if (j > 80) break;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("latency", 32'(j), 32'(lat_of(int'(n))));
        check("busy_cycles", 32'(bcnt), 32'(lat_of(int'(n))));
        check("result", B, exp_q.pop_front());
        prev_b = exp_b;
        if (interfere) begin
            start = 1'b1; A = 32'hDEADBEEF; shamt = 5'd3; arith = 1'b1;
        end
        @(negedge clk);
        check("done_width", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        if (interfere) begin
            repeat (3) @(negedge clk);
            check("dropped_busy", {31'd0, busy}, 32'd0);
            check("dropped_b", B, exp_b);
        end
        check("done_pulses", 32'(done_pulses - p0), 32'd1);
    endtask

    initial begin
        int p0;
        int d1;
        int d2;
        n_checks = 0;
        n_errors = 0;
        done_pulses = 0;
        prev_b = 32'd0;
        rst = 1'b1; start = 1'b0; A = 32'd0; shamt = 5'd0; arith = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_b", B, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0;

        run_op(32'h80000000, 5'd4,  1'b0, 32'h08000000, 1'b0);
        run_op(32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF, 1'b0);
        run_op(32'h7FFFFFFF, 5'd31, 1'b1, 32'h00000000, 1'b0);
        run_op(32'h80000000, 5'd31, 1'b0, 32'h00000001, 1'b0);
        run_op(32'h80000000, 5'd4,  1'b1, 32'hF8000000, 1'b0);
        run_op(32'h12345678, 5'd0,  1'b0, 32'h12345678, 1'b0);
        run_op(32'hF0000000, 5'd8,  1'b1, 32'hFFF00000, 1'b1);

        // reset in the third SHIFT cycle of a 10-bit shift
        @(negedge clk);
        A = 32'hFFFF0000; shamt = 5'd10; arith = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("midop_busy_before", {31'd0, busy}, 32'd1);
        p0 = done_pulses;
        rst = 1'b1;
        #1;
        check("midop_rst_b", B, 32'd0);
        check("midop_rst_busy", {31'd0, busy}, 32'd0);
        check("midop_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("midop_no_done", 32'(done_pulses - p0), 32'd0);
        check("midop_idle", {31'd0, busy}, 32'd0);
        prev_b = 32'd0;
        run_op(32'h00000100, 5'd8, 1'b0, 32'h00000001, 1'b0);

        // back-to-back with start held high
        @(negedge clk);
        A = 32'h0000000C; shamt = 5'd2; arith = 1'b0; start = 1'b1;
        d1 = -1;
        d2 = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                check("b2b_result", B, 32'h00000003);
                if (d1 < 0) d1 = i;
                else begin
                    d2 = i;
                    break;
                end
            end
        end
        start = 1'b0;
        check("b2b_period", 32'(d2 - d1), 32'd5);
        repeat (8) @(negedge clk);
        check("b2b_stopped", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
